// File: rtl/pixel_ram_arbiter.sv
// Arbiter for a shared single-port, double-banked pixel RAM: display reads
// take priority, host writes are starvation-protected, bank swaps are sequenced.
module pixel_ram_arbiter #(
    parameter int ADDRESS_WIDTH = 25,
    parameter int DATA_WIDTH    = 8,
    parameter int READ_LATENCY  = 2,
    parameter int MAX_BURST     = 16,
    parameter int STARVE_LIMIT  = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rd_req,
    input  logic [ADDRESS_WIDTH-1:0] rd_address,
    output logic                     rd_grant,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_data_valid,
    input  logic                     wr_req,
    input  logic [ADDRESS_WIDTH-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     wr_grant,
    input  logic                     swap_req,
    output logic                     bank_active,
    output logic                     swap_done,
    output logic [ADDRESS_WIDTH:0]   ram_address,
    output logic                     ram_rd,
    output logic                     ram_wr,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    input  logic [DATA_WIDTH-1:0]    ram_rdata
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(MAX_BURST - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        READ_BURST  = 2'd1,
        WRITE_BURST = 2'd2
    } state_t;

    state_t                  r_state;
    logic [BW-1:0]           r_beats;
    logic [SW-1:0]           r_starve;
    logic [READ_LATENCY-1:0] r_vpipe;
    logic                    r_bank;
    logic                    r_swap_pending;
    logic                    r_swap_done;

    logic                    w_idle;
    logic                    w_rd_beat;
    logic                    w_wr_beat;
    logic                    w_beat;
    logic                    w_burst_end;
    logic                    w_pipe_empty;
    logic                    w_swap_go;
    logic                    w_starving;
    logic                    w_to_wr;
    logic                    w_to_rd;
    logic [READ_LATENCY-1:0] w_vpipe_next;

    assign w_idle       = (r_state == IDLE);
    assign w_rd_beat    = (r_state == READ_BURST) && rd_req;
    assign w_wr_beat    = (r_state == WRITE_BURST) && wr_req;
    // Inside a burst state the owner's req being high is exactly a beat
    assign w_beat       = w_rd_beat || w_wr_beat;
    assign w_burst_end  = !w_idle && (!w_beat || (r_beats == LAST_BEAT));
    assign w_pipe_empty = (r_vpipe == '0);
    assign w_swap_go    = w_idle && r_swap_pending && w_pipe_empty;
    assign w_starving   = wr_req && (r_starve >= STARVE_MAX);
    assign w_to_wr      = w_idle && !w_swap_go && wr_req
                          && (w_starving || !rd_req);
    assign w_to_rd      = w_idle && !w_swap_go && rd_req && !w_starving;
    assign w_vpipe_next = (r_vpipe << 1) | READ_LATENCY'(w_rd_beat);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_beats        <= '0;
            r_starve       <= '0;
            r_vpipe        <= '0;
            r_bank         <= 1'b0;
            r_swap_pending <= 1'b0;
            r_swap_done    <= 1'b0;
        end else begin
            r_vpipe     <= w_vpipe_next;
            r_swap_done <= w_swap_go;
            if (w_swap_go) begin
                r_bank <= ~r_bank;
            end
            // A request landing on the executing cycle re-arms the flip
            if (swap_req) begin
                r_swap_pending <= 1'b1;
            end else if (w_swap_go) begin
                r_swap_pending <= 1'b0;
            end
            if (!wr_req || w_to_wr) begin
                r_starve <= '0;
            end else if (r_state != WRITE_BURST && r_starve != STARVE_MAX) begin
                r_starve <= r_starve + 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    r_beats <= '0;
                    if (w_to_wr) begin
                        r_state <= WRITE_BURST;
                    end else if (w_to_rd) begin
                        r_state <= READ_BURST;
                    end
                end
                READ_BURST, WRITE_BURST: begin
                    if (w_beat) begin
                        r_beats <= r_beats + 1'b1;
                    end
                    if (w_burst_end) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_grant      = (r_state == READ_BURST);
    assign wr_grant      = (r_state == WRITE_BURST);
    assign ram_rd        = w_rd_beat;
    assign ram_wr        = w_wr_beat;
    assign ram_address   = w_rd_beat ? {r_bank, rd_address}
                         : w_wr_beat ? {~r_bank, wr_address}
                         : '0;
    assign ram_wdata     = w_wr_beat ? wr_data : '0;
    assign rd_data_valid = r_vpipe[READ_LATENCY-1];
    assign rd_data       = rd_data_valid ? ram_rdata : '0;
    assign bank_active   = r_bank;
    assign swap_done     = r_swap_done;

endmodule

// File: tb/tb_pixel_ram_arbiter.sv
// Scoreboard bench for pixel_ram_arbiter: directed scenarios then random
// traffic, checked against a cycle-level behavioural model and a RAM model.
module tb_pixel_ram_arbiter;

    localparam int AW  = 25;
    localparam int DW  = 8;
    localparam int LAT = 2;
    localparam int MB  = 16;
    localparam int SL  = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_req;
    logic [AW-1:0] rd_address;
    logic          rd_grant;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;
    logic          wr_req;
    logic [AW-1:0] wr_address;
    logic [DW-1:0] wr_data;
    logic          wr_grant;
    logic          swap_req;
    logic          bank_active;
    logic          swap_done;
    logic [AW:0]   ram_address;
    logic          ram_rd;
    logic          ram_wr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    pixel_ram_arbiter #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW),
        .READ_LATENCY(LAT),
        .MAX_BURST(MB),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rd_req(rd_req),
        .rd_address(rd_address),
        .rd_grant(rd_grant),
        .rd_data(rd_data),
        .rd_data_valid(rd_data_valid),
        .wr_req(wr_req),
        .wr_address(wr_address),
        .wr_data(wr_data),
        .wr_grant(wr_grant),
        .swap_req(swap_req),
        .bank_active(bank_active),
        .swap_done(swap_done),
        .ram_address(ram_address),
        .ram_rd(ram_rd),
        .ram_wr(ram_wr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // RAM environment: 16 words per bank, fixed read latency
    logic [DW-1:0] ram [32];
    logic [DW-1:0] rpipe [LAT];
    logic          e_rd = 1'b0;
    logic          e_wr = 1'b0;
    logic [AW:0]   e_addr = '0;
    logic [DW-1:0] e_wd = '0;

    function automatic int ridx(logic [AW:0] a);
        return int'({a[AW], a[3:0]});
    endfunction

    always @(negedge clk) begin
        e_rd   = ram_rd;
        e_wr   = ram_wr;
        e_addr = ram_address;
        e_wd   = ram_wdata;
    end

    always @(posedge clk) begin
        if (e_wr) ram[ridx(e_addr)] = e_wd;
        for (int k = LAT - 1; k > 0; k--) rpipe[k] = rpipe[k-1];
        rpipe[0] = e_rd ? ram[ridx(e_addr)] : DW'($urandom);
        ram_rdata = rpipe[LAT-1];
    end

    // Observation helpers for the stimulus side
    logic seen_rd = 1'b0;
    logic seen_wr = 1'b0;
    logic seen_msb = 1'b0;
    int   n_swap = 0;
    int   n_valid = 0;

    always @(negedge clk) begin
        seen_rd  = ram_rd;
        seen_wr  = ram_wr;
        seen_msb = ram_address[AW];
        if (swap_done === 1'b1) n_swap++;
    end

    // Behavioural reference model
    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } sb_t;

    sb_t           sbq[$];
    logic [DW-1:0] mem [32];
    int            owner = 0;
    int            beats = 0;
    int            waitc = 0;
    int            last_rd = -100;
    bit            bank = 0;
    bit            pend = 0;
    bit            done_q = 0;
    bit            mvalid = 0;

    always @(negedge clk) begin : model
        bit            xr;
        bit            xw;
        bit            go;
        int            nxt;
        logic [AW:0]   xa;
        logic [DW-1:0] xd;
        xr = (owner == 1) && rd_req;
        xw = (owner == 2) && wr_req;
        xa = xr ? {bank, rd_address} : (xw ? {~bank, wr_address} : '0);
        xd = xw ? wr_data : '0;
        if (mvalid) begin
            chk("rd_grant", rd_grant, owner == 1);
            chk("wr_grant", wr_grant, owner == 2);
            chk("ram_rd", ram_rd, xr);
            chk("ram_wr", ram_wr, xw);
            chk("ram_address", ram_address, xa);
            chk("ram_wdata", ram_wdata, xd);
            chk("bank_active", bank_active, bank);
            chk("swap_done", swap_done, done_q);
        end
        if (reset) begin
            owner = 0; beats = 0; waitc = 0; last_rd = -100;
            bank = 0; pend = 0; done_q = 0; mvalid = 1;
            while (sbq.size() > 0 && sbq[$].due > cyc) void'(sbq.pop_back());
        end else if (mvalid) begin
            go = (owner == 0) && pend && (cyc - last_rd > LAT);
            if (xr) begin
                sbq.push_back('{mem[{bank, rd_address[3:0]}], cyc + LAT});
                last_rd = cyc;
            end
            if (xw) mem[{~bank, wr_address[3:0]}] = wr_data;
            nxt = owner;
            if (owner != 0) begin
                if (xr || xw) beats++;
                if (!(xr || xw) || beats == MB) nxt = 0;
            end else begin
                beats = 0;
                if (go) nxt = 0;
                else if (wr_req && waitc >= SL) nxt = 2;
                else if (rd_req) nxt = 1;
                else if (wr_req) nxt = 2;
            end
            if (!wr_req || (owner == 0 && nxt == 2)) waitc = 0;
            else if (owner != 2 && waitc < SL) waitc++;
            done_q = go;
            if (go) bank = ~bank;
            if (swap_req) pend = 1;
            else if (go) pend = 0;
            owner = nxt;
        end
    end

    // Monitor: pops the scoreboard whenever read data is presented
    always @(negedge clk) begin : monitor
        sb_t e;
        if (mvalid) begin
            if (rd_data_valid) begin
                n_valid++;
                chk("rd_sb_nonempty", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("rd_data", rd_data, e.d);
                    chk("rd_latency", cyc, e.due);
                end
            end else begin
                chk("rd_data_idle", rd_data, 0);
                while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    chk("rd_valid_missing", rd_data_valid, 1);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int nb;
        int c0;
        int c1;
        int n;
        int s0;
        for (int i = 0; i < 32; i++) begin
            ram[i] = DW'(i * 37 + 5);
            mem[i] = DW'(i * 37 + 5);
        end
        for (int k = 0; k < LAT; k++) rpipe[k] = '0;
        ram_rdata = '0;
        reset = 1'b1; rd_req = 0; wr_req = 0; swap_req = 0;
        rd_address = '0; wr_address = '0; wr_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // 20-beat read: 16 beats, one dead cycle, 4 beats
        s0 = n_valid; nb = 0; c0 = 0; c1 = 0;
        rd_req = 1'b1;
        for (int i = 0; i < 200 && nb < 20; i++) begin
            tick();
            if (seen_rd) begin
                if (nb == 0) c0 = cyc;
                nb++;
                c1 = cyc;
                rd_address = rd_address + 1'b1;
            end
        end
        rd_req = 1'b0;
        chk("read20_beats", nb, 20);
        chk("read20_span", c1 - c0, 20);
        repeat (5) tick();
        chk("read20_valids", n_valid - s0, 20);

        // Simultaneous requests: read wins, write follows
        rd_address = 4'd3; wr_address = 4'd9; wr_data = 8'h5a;
        rd_req = 1'b1; wr_req = 1'b1;
        tick();
        tick();
        chk("simul_rd_first", rd_grant, 1);
        chk("simul_no_wr", wr_grant, 0);
        repeat (4) tick();
        rd_req = 1'b0;
        nb = 0;
        for (int i = 0; i < 50 && !seen_wr; i++) tick();
        chk("simul_wr_seen", seen_wr, 1);
        chk("simul_wr_msb", seen_msb, 1);
        wr_req = 1'b0;
        repeat (4) tick();

        // Starvation under continuous reads
        rd_req = 1'b1; wr_req = 1'b1; n = 0;
        for (int i = 0; i < 200 && !wr_grant; i++) begin
            rd_address = AW'($urandom_range(0, 15));
            wr_address = AW'($urandom_range(0, 15));
            wr_data = DW'($urandom);
            tick();
            n++;
        end
        chk("starve_granted", wr_grant, 1);
        chk("starve_bound", n <= SL + MB + 2, 1);
        for (int i = 0; i < 20 && !seen_wr; i++) tick();
        chk("starve_wr_msb", seen_msb, 1);
        rd_req = 1'b0; wr_req = 1'b0;
        repeat (4) tick();

        // Swap during read burst
        s0 = n_swap;
        rd_req = 1'b1;
        repeat (4) tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("swap_held_off", bank_active, 0);
        repeat (3) tick();
        rd_req = 1'b0;
        repeat (8) tick();
        chk("swap_once", n_swap - s0, 1);
        chk("swap_bank", bank_active, 1);
        rd_req = 1'b1; rd_address = 4'd7;
        for (int i = 0; i < 20 && !seen_rd; i++) tick();
        chk("swap_rd_msb", seen_msb, 1);
        rd_req = 1'b0;
        repeat (4) tick();

        // Reset on the fifth write beat
        wr_req = 1'b1; nb = 0;
        for (int i = 0; i < 50 && nb < 4; i++) begin
            wr_address = AW'($urandom_range(0, 15));
            wr_data = DW'($urandom);
            tick();
            if (seen_wr) nb++;
        end
        chk("rst_beats", nb, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_wr_grant", wr_grant, 0);
        chk("rst_ram_wr", ram_wr, 0);
        chk("rst_bank", bank_active, 0);
        chk("rst_valid", rd_data_valid, 0);
        wr_req = 1'b0;
        repeat (4) tick();

        // Two swap pulses while one is pending
        s0 = n_swap;
        rd_req = 1'b1;
        repeat (2) tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        repeat (2) tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        repeat (2) tick();
        rd_req = 1'b0;
        repeat (10) tick();
        chk("dswap_once", n_swap - s0, 1);
        chk("dswap_bank", bank_active, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) rd_req = ~rd_req;
            if ($urandom_range(0, 7) == 0) wr_req = ~wr_req;
            rd_address = AW'($urandom_range(0, 15));
            wr_address = AW'($urandom_range(0, 15));
            wr_data = DW'($urandom);
            swap_req = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        rd_req = 0; wr_req = 0; swap_req = 0; reset = 0;
        repeat (10) tick();
        chk("sb_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_ram_arbiter.md
Name: pixel_ram_arbiter

Overview:
Shares one single-port, double-banked pixel RAM between two requesters. The display refill path issues read bursts and has priority. The host loader issues write bursts into the back bank and is protected from starvation. The block also owns the bank-swap sequencing, so a frame flip never lands mid-burst or with reads still in flight.

Parameters:
ADDRESS_WIDTH, 25, per-bank pixel address width; the RAM address is ADDRESS_WIDTH+1 bits with the bank bit as MSB.
DATA_WIDTH, 8, pixel word width (RGB332).
READ_LATENCY, 2, cycles from ram_rd to ram_rdata valid; must be at least 1.
MAX_BURST, 16, maximum beats per grant before re-arbitration; must be at least 1.
STARVE_LIMIT, 64, cycles a pending write may wait before it wins over reads.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rd_req  in  1  display read request; held high while beats remain
rd_address  in  ADDRESS_WIDTH  display read address (front bank implied)
rd_grant  out  1  read burst owns the RAM
rd_data  out  DATA_WIDTH  read data
rd_data_valid  out  1  rd_data valid this cycle
wr_req  in  1  host write request; held high while beats remain
wr_address  in  ADDRESS_WIDTH  host write address (back bank implied)
wr_data  in  DATA_WIDTH  host write data
wr_grant  out  1  write burst owns the RAM
swap_req  in  1  one-cycle pulse requesting a frame flip
bank_active  out  1  front (display) bank
swap_done  out  1  one-cycle pulse when the flip executes
ram_address  out  ADDRESS_WIDTH+1  {bank, address}
ram_rd  out  1  RAM read strobe
ram_wr  out  1  RAM write strobe
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM read data

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE; all strobes, grants and valids 0; bank_active 0; ram_address 0; ram_wdata 0; swap_pending 0; starve count 0; beat count 0.
- States and grants:
  - States are IDLE, READ_BURST and WRITE_BURST.
  - rd_grant equals (state==READ_BURST). wr_grant equals (state==WRITE_BURST). Both are decoded from the state register only.
- Beat transfer:
  - A beat transfers when req and grant are both high in the same cycle.
  - Read beat: ram_rd=1 and ram_address={bank_active, rd_address}.
  - Write beat: ram_wr=1, ram_address={~bank_active, wr_address}, ram_wdata=wr_data.
  - ram_rd and ram_wr are combinational from state and req, and are never high together.
- Burst end:
  - A burst ends on the cycle req is low, or on the beat that brings the beat count to MAX_BURST.
  - The next state is then IDLE, which gives a guaranteed dead cycle between bursts.
- IDLE priority, highest first:
  1. swap_pending with the read pipeline empty executes the swap.
  2. wr_req with starve count >= STARVE_LIMIT goes to WRITE_BURST.
  3. rd_req goes to READ_BURST.
  4. wr_req goes to WRITE_BURST.
  5. Otherwise stay in IDLE.
  - A swap that is pending but blocked by in-flight reads does not block grants.
- Swap:
  - swap_req sets swap_pending. A repeated swap_req while pending is absorbed; only one swap executes.
  - Executing the swap toggles bank_active, pulses swap_done for 1 cycle and clears swap_pending. No grant is issued that cycle.
  - If swap_req arrives in the same cycle a swap executes, swap_pending stays set.
- Read pipeline:
  - A READ_LATENCY-deep valid shift register is fed by ram_rd.
  - rd_data_valid is the last stage of that register. rd_data equals ram_rdata when valid, else 0.
  - The pipeline is empty when all stages are 0.
- Starvation:
  - The starve count increments, saturating at STARVE_LIMIT, each cycle wr_req=1 and state!=WRITE_BURST.
  - It clears on entry to WRITE_BURST or when wr_req=0.
- Beat count:
  - Cleared on burst entry; +1 per beat.
  - Width is clog2(MAX_BURST+1).
- Reset mid-burst: returns to IDLE the next cycle, drops grants, clears the valid pipeline (in-flight reads are discarded) and clears swap_pending.

Test Plan:
- Read burst only (MAX_BURST=16): rd_req held for 20 beats, addresses 0..19 -> grant drops after beat 16, 1 IDLE cycle, regrant for beats 17..20; rd_data_valid follows each ram_rd 2 cycles later; ram_address MSB=0.
- Simultaneous rd_req and wr_req from IDLE, starve count 0 -> READ_BURST first; WRITE_BURST only after rd_req falls; write ram_address MSB=1 (back bank).
- Starvation (STARVE_LIMIT=64): rd_req permanently high and wr_req high -> wr_grant asserts within 64+MAX_BURST+2 cycles; write lands at {1, wr_address}.
- Swap during read burst: swap_req mid-burst -> no flip until burst end plus 2-cycle pipeline drain; bank_active 0->1 with a single swap_done pulse; next read ram_address MSB=1.
- Double swap_req pulses while pending -> exactly one toggle and one swap_done.
- Reset asserted mid write burst (beat 5) -> next cycle wr_grant=0, ram_wr=0, state IDLE, bank_active=0, rd_data_valid=0.
